// File: rtl/mmio_bus_pkg.sv
// rtl/mmio_bus_pkg.sv - shared types and width helpers for the MMIO bus controller
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_IO,
    ST_RESP
  } state_t;

  localparam logic [31:0] DEFAULT_IO_BASE = 32'hFFFF_FC00;

  // Channel index width; a single channel still needs one bit to carry the index.
  function automatic int ch_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Byte-offset width inside one channel window.
  function automatic int off_w(input int span);
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/mmio_bus_ctrl_if.sv
// rtl/mmio_bus_ctrl_if.sv - core-side request/response bus of the MMIO controller
interface mmio_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - combinational memory/IO address decoder
module mmio_addr_decode
  import mmio_bus_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                N_CH    = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DEFAULT_IO_BASE),
  parameter int                CH_SPAN = 16
) (
  input  logic [ADDR_W-1:0]          addr,
  output logic                       is_io,
  output logic [ch_w(N_CH)-1:0]      ch,
  output logic [off_w(CH_SPAN)-1:0]  off,
  output logic                       misaligned,
  output logic                       out_of_range
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int OFF_W = off_w(CH_SPAN);

  logic [ADDR_W-1:0] rel;
  logic [ADDR_W-1:0] win;

  // Window index is the IO-relative address divided by the power-of-two span.
  always_comb begin
    rel          = addr - IO_BASE;
    win          = rel >> OFF_W;
    is_io        = (addr >= IO_BASE);
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = is_io && (win >= ADDR_W'(N_CH));
    ch           = win[CH_W-1:0];
    off          = rel[OFF_W-1:0];
  end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// rtl/mmio_bus_ctrl.sv - single-outstanding load/store router to data memory or IO channels
module mmio_bus_ctrl
  import mmio_bus_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                N_CH    = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(DEFAULT_IO_BASE),
  parameter int                CH_SPAN = 16,
  parameter int                MEM_LAT = 2,
  parameter int                TIMEOUT = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  mmio_bus_ctrl_if.slave             bus,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [N_CH-1:0]            io_sel,
  output logic                       io_we,
  output logic [off_w(CH_SPAN)-1:0]  io_off,
  output logic [DATA_W-1:0]          io_wdata,
  input  logic [N_CH-1:0]            io_ack,
  input  logic [N_CH*DATA_W-1:0]     io_rdata
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int OFF_W = off_w(CH_SPAN);

  state_t            state;
  logic              wr_q;
  logic [CH_W-1:0]   ch_q;
  logic [15:0]       cnt;

  logic              dec_is_io;
  logic [CH_W-1:0]   dec_ch;
  logic [OFF_W-1:0]  dec_off;
  logic              dec_mis;
  logic              dec_oor;

  mmio_addr_decode #(
    .ADDR_W (ADDR_W),
    .N_CH   (N_CH),
    .IO_BASE(IO_BASE),
    .CH_SPAN(CH_SPAN)
  ) u_decode (
    .addr        (bus.req_addr),
    .is_io       (dec_is_io),
    .ch          (dec_ch),
    .off         (dec_off),
    .misaligned  (dec_mis),
    .out_of_range(dec_oor)
  );

  // Request FSM; every output is a register updated on the transition that needs it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      io_sel        <= '0;
      io_we         <= 1'b0;
      io_off        <= '0;
      io_wdata      <= '0;
      wr_q          <= 1'b0;
      ch_q          <= '0;
      cnt           <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            wr_q          <= bus.req_write;
            cnt           <= '0;
            if (dec_mis || dec_oor) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else if (!dec_is_io) begin
              state     <= ST_MEM;
              mem_en    <= 1'b1;
              mem_we    <= bus.req_write;
              mem_addr  <= bus.req_addr;
              mem_wdata <= bus.req_wdata;
            end else begin
              state    <= ST_IO;
              ch_q     <= dec_ch;
              io_sel   <= N_CH'(1) << dec_ch;
              io_we    <= bus.req_write;
              io_off   <= dec_off;
              io_wdata <= bus.req_wdata;
            end
          end
        end
        ST_MEM: begin
          // Stores complete after one write cycle; loads wait out the read latency.
          mem_we <= 1'b0;
          if (wr_q || (cnt == 16'(MEM_LAT - 1))) begin
            state         <= ST_RESP;
            mem_en        <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= wr_q ? '0 : mem_rdata;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_IO: begin
          // An ack on the final wait cycle still counts as success.
          if (io_ack[ch_q]) begin
            state         <= ST_RESP;
            io_sel        <= '0;
            io_we         <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= wr_q ? '0 : io_rdata[ch_q*DATA_W +: DATA_W];
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            state         <= ST_RESP;
            io_sel        <= '0;
            io_we         <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb/tb_mmio_bus_ctrl.sv - self-checking bench for mmio_bus_ctrl
module tb_mmio_bus_ctrl;

  localparam int          N_CH    = 4;
  localparam int          CH_SPAN = 16;
  localparam int          MEM_LAT = 2;
  localparam int          TIMEOUT = 8;
  localparam int          W       = 14;
  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mmio_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  logic         mem_en, mem_we, io_we;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata, io_wdata;
  logic [3:0]   io_sel, io_off, io_ack;
  logic [127:0] io_rdata;
  logic [31:0]  io_word [4];

  assign io_rdata = {io_word[3], io_word[2], io_word[1], io_word[0]};

  mmio_bus_ctrl #(
    .ADDR_W(32), .DATA_W(32), .N_CH(N_CH), .IO_BASE(IO_BASE),
    .CH_SPAN(CH_SPAN), .MEM_LAT(MEM_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .io_sel(io_sel), .io_we(io_we), .io_off(io_off),
    .io_wdata(io_wdata), .io_ack(io_ack), .io_rdata(io_rdata)
  );

  int checks = 0;
  int failures = 0;

  logic        rv [1:W], rdy [1:W], er [1:W], men [1:W], mwe [1:W], iwe [1:W];
  logic [31:0] rd [1:W], maddr [1:W], iwd [1:W];
  logic [3:0]  sel [1:W], off [1:W];
  int          n_rsp, rsp_at;

  // Behavioural expectation: response cycle (from acceptance), error flag, read data.
  function automatic void model(input logic [31:0] a, input logic w, input int ack_k,
                                output int cyc, output logic err, output logic [31:0] data);
    int ch;
    err  = 1'b0;
    data = 32'h0;
    if ((a % 4) != 0) begin
      cyc = 1; err = 1'b1;
    end else if (a < IO_BASE) begin
      cyc  = w ? 2 : MEM_LAT + 1;
      data = w ? 32'h0 : mem_rdata;
    end else begin
      ch = int'((a - IO_BASE) / CH_SPAN);
      if (ch >= N_CH) begin
        cyc = 1; err = 1'b1;
      end else if (ack_k >= 0 && ack_k < TIMEOUT) begin
        cyc  = ack_k + 2;
        data = w ? 32'h0 : io_word[ch];
      end else begin
        cyc = TIMEOUT + 1; err = 1'b1;
      end
    end
  endfunction

  // Presents one request, then records W cycles of outputs while playing the IO peripheral.
  task automatic drive_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int ack_k, input int spur_ch);
    logic [3:0] tgt, spur;
    int ch;
    tgt  = 4'b0;
    spur = (spur_ch >= 0) ? 4'(1 << spur_ch) : 4'b0;
    if (a >= IO_BASE) begin
      ch = int'((a - IO_BASE) / CH_SPAN);
      if (ch < N_CH) tgt = 4'(1 << ch);
    end
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clock); #1;
    bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    io_ack = ((ack_k == 0) ? tgt : 4'b0) | spur;
    n_rsp = 0; rsp_at = -1;
    for (int c = 1; c <= W; c++) begin
      @(negedge clock);
      rv[c] = bus.rsp_valid; rdy[c] = bus.req_ready; er[c] = bus.rsp_err; rd[c] = bus.rsp_rdata;
      men[c] = mem_en; mwe[c] = mem_we; maddr[c] = mem_addr;
      sel[c] = io_sel; off[c] = io_off; iwe[c] = io_we; iwd[c] = io_wdata;
      if (bus.rsp_valid) begin n_rsp++; rsp_at = c; end
      @(posedge clock); #1;
      io_ack = ((c == ack_k) ? tgt : 4'b0) | spur;
    end
    io_ack = 4'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, mem_en, mem_we, io_we, io_sel} !== 10'b1000000000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {bus.req_ready, bus.rsp_valid, bus.rsp_err, mem_en, mem_we, io_we, io_sel}, 10'b1000000000);
    end
    checks++;
    if ({bus.rsp_rdata, mem_addr, mem_wdata, io_off, io_wdata} !== 132'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {bus.rsp_rdata, mem_addr, mem_wdata, io_off, io_wdata});
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_mem_load();
    logic bad;
    mem_rdata = 32'h1234_5678;
    drive_txn(32'h0000_0010, 1'b0, 32'h0, -1, -1);
    checks++;
    if (n_rsp !== 1 || rsp_at !== 3) begin
      failures++; $display("FAIL mem_load_cycle: got n=%0d at=%0d expected n=1 at=3", n_rsp, rsp_at);
    end
    checks++;
    if (rsp_at > 0 && {er[rsp_at], rd[rsp_at]} !== {1'b0, 32'h1234_5678}) begin
      failures++; $display("FAIL mem_load_data: got err=%b rdata=%h expected err=0 rdata=12345678", er[rsp_at], rd[rsp_at]);
    end
    bad = 1'b0;
    for (int c = 1; c <= W; c++) if (mwe[c] !== 1'b0) bad = 1'b1;
    for (int c = 1; c <= 2; c++) if (men[c] !== 1'b1 || maddr[c] !== 32'h10) bad = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL mem_load_strobes: got bad=%b expected 0", bad);
    end
    checks++;
    if (rdy[4] !== 1'b1 || rdy[3] !== 1'b0) begin
      failures++; $display("FAIL mem_load_ready: got rdy3=%b rdy4=%b expected 0 1", rdy[3], rdy[4]);
    end
  endtask

  task automatic test_io_store();
    logic bad;
    drive_txn(32'hFFFF_FC14, 1'b1, 32'hCAFE_0001, 3, -1);
    checks++;
    if (n_rsp !== 1 || rsp_at !== 5) begin
      failures++; $display("FAIL io_store_cycle: got n=%0d at=%0d expected n=1 at=5", n_rsp, rsp_at);
    end
    checks++;
    if (rsp_at > 0 && {er[rsp_at], rd[rsp_at]} !== 33'h0) begin
      failures++; $display("FAIL io_store_rsp: got err=%b rdata=%h expected 0 0", er[rsp_at], rd[rsp_at]);
    end
    bad = 1'b0;
    for (int c = 1; c <= 4; c++)
      if (sel[c] !== 4'b0010 || off[c] !== 4'd4 || iwe[c] !== 1'b1 || iwd[c] !== 32'hCAFE_0001 || men[c] !== 1'b0)
        bad = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL io_store_hold: got bad=%b expected 0", bad);
    end
  endtask

  task automatic test_io_timeout();
    logic bad;
    io_word[2] = 32'hDEAD_BEEF;
    drive_txn(32'hFFFF_FC20, 1'b0, 32'h0, -1, 0);
    checks++;
    if (n_rsp !== 1 || rsp_at !== 9) begin
      failures++; $display("FAIL io_timeout_cycle: got n=%0d at=%0d expected n=1 at=9", n_rsp, rsp_at);
    end
    checks++;
    if (rsp_at > 0 && {er[rsp_at], rd[rsp_at]} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL io_timeout_rsp: got err=%b rdata=%h expected 1 0", er[rsp_at], rd[rsp_at]);
    end
    bad = 1'b0;
    for (int c = 1; c <= 8; c++) if (sel[c] !== 4'b0100) bad = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL io_timeout_sel: got bad=%b expected 0", bad);
    end
  endtask

  task automatic test_ack_at_timeout();
    io_word[3] = 32'h5A5A_0033;
    drive_txn(32'hFFFF_FC30, 1'b0, 32'h0, TIMEOUT - 1, -1);
    checks++;
    if (rsp_at !== TIMEOUT + 1 || er[TIMEOUT + 1] !== 1'b0 || rd[TIMEOUT + 1] !== 32'h5A5A_0033) begin
      failures++; $display("FAIL ack_at_timeout: got at=%0d err=%b rdata=%h expected at=%0d err=0 rdata=5a5a0033",
                           rsp_at, er[TIMEOUT + 1], rd[TIMEOUT + 1], TIMEOUT + 1);
    end
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [2];
    logic bad;
    addrs[0] = 32'h0000_0002;
    addrs[1] = 32'hFFFF_FC40;
    for (int i = 0; i < 2; i++) begin
      drive_txn(addrs[i], 1'b0, 32'h0, 0, -1);
      bad = 1'b0;
      for (int c = 1; c <= W; c++) if (men[c] !== 1'b0 || sel[c] !== 4'b0) bad = 1'b1;
      checks++;
      if (n_rsp !== 1 || rsp_at !== 1 || er[1] !== 1'b1 || rd[1] !== 32'h0 || bad !== 1'b0) begin
        failures++; $display("FAIL decode_err[%0d]: got n=%0d at=%0d err=%b side=%b expected n=1 at=1 err=1 side=0",
                             i, n_rsp, rsp_at, er[1], bad);
      end
    end
  endtask

  task automatic test_boundaries();
    mem_rdata  = 32'h0BAD_F00D;
    io_word[0] = 32'h0000_C0DE;
    drive_txn(IO_BASE - 32'd4, 1'b0, 32'h0, 0, -1);
    checks++;
    if (men[1] !== 1'b1 || sel[1] !== 4'b0 || rsp_at !== 3 || rd[3] !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL bound_below: got men=%b sel=%b at=%0d rdata=%h expected 1 0000 3 0badf00d",
                           men[1], sel[1], rsp_at, rd[3]);
    end
    drive_txn(IO_BASE, 1'b0, 32'h0, 0, -1);
    checks++;
    if (sel[1] !== 4'b0001 || rsp_at !== 2 || er[2] !== 1'b0 || rd[2] !== 32'h0000_C0DE) begin
      failures++; $display("FAIL bound_base: got sel=%b at=%0d err=%b rdata=%h expected 0001 2 0 0000c0de",
                           sel[1], rsp_at, er[2], rd[2]);
    end
    drive_txn(IO_BASE + N_CH * CH_SPAN, 1'b1, 32'h1, 0, -1);
    checks++;
    if (rsp_at !== 1 || er[1] !== 1'b1) begin
      failures++; $display("FAIL bound_top: got at=%0d err=%b expected 1 1", rsp_at, er[1]);
    end
    drive_txn(32'hFFFF_FFFC, 1'b0, 32'h0, 0, -1);
    checks++;
    if (rsp_at !== 1 || er[1] !== 1'b1 || sel[1] !== 4'b0) begin
      failures++; $display("FAIL bound_last: got at=%0d err=%b sel=%b expected 1 1 0000", rsp_at, er[1], sel[1]);
    end
  endtask

  task automatic test_reset_abort();
    int spurious;
    // Abort a memory load in its second MEM cycle.
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1 || mem_en !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL abort_mem_idle: got ready=%b mem_en=%b rsp=%b expected 1 0 0",
                           bus.req_ready, mem_en, bus.rsp_valid);
    end
    // Abort an IO load, then ack every channel afterwards.
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_addr = IO_BASE;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    io_ack = 4'b1111;
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0 || io_sel !== 4'b0) spurious++;
      @(posedge clock); #1;
      io_ack = 4'b0;
    end
    checks++;
    if (spurious !== 0) begin
      failures++; $display("FAIL abort_no_rsp: got %0d bad cycles expected 0", spurious);
    end
    mem_rdata = 32'h7777_0004;
    drive_txn(32'h0000_0004, 1'b0, 32'h0, -1, -1);
    checks++;
    if (n_rsp !== 1 || rsp_at !== 3 || rd[3] !== 32'h7777_0004 || er[3] !== 1'b0) begin
      failures++; $display("FAIL abort_next: got n=%0d at=%0d rdata=%h err=%b expected 1 3 77770004 0",
                           n_rsp, rsp_at, rd[3], er[3]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind, ch, ack_k, spur, ecyc, r;
      logic w, eerr, low_bad;
      logic [31:0] a, erd;
      kind = int'($urandom_range(0, 3));
      ch   = int'($urandom_range(0, N_CH - 1));
      w    = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      for (int j = 0; j < 4; j++) io_word[j] = $urandom;
      case (kind)
        0:       a = $urandom & 32'h7FFF_FFFC;
        1:       a = IO_BASE + 32'(ch * CH_SPAN) + 32'($urandom_range(0, 3) * 4);
        2:       a = (IO_BASE + 32'(N_CH * CH_SPAN) + 32'($urandom_range(0, 32'h3BF))) & 32'hFFFF_FFFC;
        default: a = $urandom | 32'h1;
      endcase
      ack_k = int'($urandom_range(0, TIMEOUT + 2));
      if (ack_k > TIMEOUT + 1) ack_k = -1;
      r    = int'($urandom_range(0, N_CH - 2));
      spur = (kind == 1) ? (ch + 1 + r) % N_CH : -1;
      model(a, w, ack_k, ecyc, eerr, erd);
      drive_txn(a, w, $urandom, ack_k, spur);
      checks++;
      if (n_rsp !== 1 || rsp_at !== ecyc) begin
        failures++; $display("FAIL rnd_cycle[%0d] a=%h: got n=%0d at=%0d expected n=1 at=%0d", i, a, n_rsp, rsp_at, ecyc);
      end
      checks++;
      if (rsp_at > 0 && {er[rsp_at], rd[rsp_at]} !== {eerr, erd}) begin
        failures++; $display("FAIL rnd_rsp[%0d] a=%h: got err=%b rdata=%h expected err=%b rdata=%h",
                             i, a, er[rsp_at], rd[rsp_at], eerr, erd);
      end
      low_bad = 1'b0;
      for (int c = 1; c <= ecyc; c++) if (rdy[c] !== 1'b0) low_bad = 1'b1;
      checks++;
      if (low_bad !== 1'b0 || rdy[ecyc + 1] !== 1'b1) begin
        failures++; $display("FAIL rnd_ready[%0d]: got low_bad=%b after=%b expected 0 1", i, low_bad, rdy[ecyc + 1]);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    io_ack = 4'b0; mem_rdata = 32'h0;
    for (int j = 0; j < 4; j++) io_word[j] = 32'h0;
    test_reset();
    test_mem_load();
    test_io_store();
    test_io_timeout();
    test_ack_at_timeout();
    test_decode_err();
    test_boundaries();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
